// File: rtl/ppu_bus_sequencer.sv
// Sequencer for the multiplexed PPU address/data bus. It arbitrates between
// the render-fetch and CPU requesters and runs ALE / hold / strobe / recover phases.
module ppu_bus_sequencer #(
  parameter int ALE_CYC = 1,
  parameter int STB_CYC = 2
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        renReq,
  input  logic [13:0] renAddr,
  input  logic        cpuReq,
  input  logic        cpuWrite,
  input  logic [13:0] cpuAddr,
  input  logic [7:0]  cpuWdata,
  output logic        renAck,
  output logic        cpuAck,
  output logic [7:0]  rdata,
  output logic [7:0]  adOut,
  output logic        adOe,
  input  logic [7:0]  adIn,
  output logic [5:0]  addrHi,
  output logic        ale,
  output logic        latchOeN,
  output logic        rdN,
  output logic        wrN
);

  // state   | meaning
  // IDLE    | waiting for a request; grants and captures it
  // ADDR    | ALE high, low address driven on AD
  // HOLD    | ALE low, address still driven so the latch closes on it
  // STROBE  | /RD or /WR low; read data sampled on the last cycle
  // RECOVER | strobes released, AD floated, ack pulsed
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    HOLD    = 3'd2,
    STROBE  = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam logic [3:0] ALE_LOAD = 4'(ALE_CYC - 1);
  localparam logic [3:0] STB_LOAD = 4'(STB_CYC - 1);

  state_t      state;
  state_t      nextState;
  logic [3:0]  phaseCnt;
  logic [13:0] addrReg;
  logic [7:0]  wdataReg;
  logic        writeReg;
  logic        grantCpu;
  logic [1:0]  renStreak;
  logic        takeCpu;
  logic        takeRen;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // latchOeN doubles as the "out of reset" flag: no grant on the first edge after release.
  always_comb begin
    nextState = state;
    takeCpu   = 1'b0;
    takeRen   = 1'b0;
    case (state)
      IDLE: begin
        if (!latchOeN) begin
          if (cpuReq && (!renReq || (renStreak == 2'd2))) begin
            takeCpu = 1'b1;
          end else if (renReq) begin
            takeRen = 1'b1;
          end
          if (takeCpu || takeRen) begin
            nextState = ADDR;
          end
        end
      end
      ADDR:    if (phaseCnt == 4'd0) nextState = HOLD;
      HOLD:    nextState = STROBE;
      STROBE:  if (phaseCnt == 4'd0) nextState = RECOVER;
      RECOVER: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      phaseCnt <= 4'd0;
    end else if (nextState != state) begin
      case (nextState)
        ADDR:    phaseCnt <= ALE_LOAD;
        STROBE:  phaseCnt <= STB_LOAD;
        default: phaseCnt <= 4'd0;
      endcase
    end else if (phaseCnt != 4'd0) begin
      phaseCnt <= phaseCnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      addrReg   <= 14'd0;
      wdataReg  <= 8'd0;
      writeReg  <= 1'b0;
      grantCpu  <= 1'b0;
      renStreak <= 2'd0;
      latchOeN  <= 1'b1;
    end else begin
      latchOeN <= 1'b0;
      if (takeCpu) begin
        addrReg   <= cpuAddr;
        wdataReg  <= cpuWdata;
        writeReg  <= cpuWrite;
        grantCpu  <= 1'b1;
        renStreak <= 2'd0;
      end else if (takeRen) begin
        addrReg   <= renAddr;
        writeReg  <= 1'b0;
        grantCpu  <= 1'b0;
        // Streak only counts render grants that actually made the CPU wait.
        renStreak <= cpuReq ? renStreak + 2'd1 : 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rdata <= 8'd0;
    end else if ((state == STROBE) && !writeReg && (phaseCnt == 4'd0)) begin
      rdata <= adIn;
    end
  end

  always_comb begin
    ale    = (state == ADDR);
    adOe   = 1'b0;
    adOut  = 8'd0;
    rdN    = 1'b1;
    wrN    = 1'b1;
    renAck = 1'b0;
    cpuAck = 1'b0;
    case (state)
      ADDR, HOLD: begin
        adOe  = 1'b1;
        adOut = addrReg[7:0];
      end
      STROBE: begin
        if (writeReg) begin
          adOe  = 1'b1;
          adOut = wdataReg;
          wrN   = 1'b0;
        end else begin
          rdN = 1'b0;
        end
      end
      RECOVER: begin
        renAck = !grantCpu;
        cpuAck = grantCpu;
      end
      default: ;
    endcase
  end

  assign addrHi = addrReg[13:8];

endmodule
